// File: rtl/cp0_exc_ctrl.sv
// CP0 exception/interrupt controller at the M stage.
// It holds SR, Cause, EPC and PRId, and drives the pipeline flush request.
module cp0_exc_ctrl #(
    parameter logic [31:0] PRID     = 32'h4255_4141,
    parameter logic [4:0]  EXC_ADEL = 5'd4,
    parameter logic [4:0]  EXC_ADES = 5'd5,
    parameter logic [4:0]  EXC_OV   = 5'd12
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  A1,
    input  logic [4:0]  A2,
    input  logic [31:0] DIn,
    input  logic        WE,
    input  logic [31:0] PC,
    input  logic        BDIn,
    input  logic [4:0]  ExcCodeIn,
    input  logic [1:0]  ExcMSel,
    input  logic        EXLClr,
    input  logic [5:0]  HWInt,
    output logic        Req,
    output logic [31:0] EPCOut,
    output logic [31:0] DOut
);

    localparam logic [4:0] REG_SR    = 5'd12;
    localparam logic [4:0] REG_CAUSE = 5'd13;
    localparam logic [4:0] REG_EPC   = 5'd14;
    localparam logic [4:0] REG_PRID  = 5'd15;

    logic [5:0]  im_q, im_d;
    logic        exl_q, exl_d;
    logic        ie_q, ie_d;
    logic        bd_q, bd_d;
    logic [5:0]  ip_q, ip_d;
    logic [4:0]  exccode_q, exccode_d;
    logic [31:0] epc_q, epc_d;

    logic [4:0]  sel_code;
    logic        int_req;
    logic        exc_req;
    logic [31:0] pc_base;
    logic [31:0] epc_target;
    logic [31:0] sr_val;
    logic [31:0] cause_val;

    // The older fault from F/D beats the ALU's exception select.
    always_comb begin
        sel_code = 5'd0;
        if (ExcCodeIn != 5'd0) begin
            sel_code = ExcCodeIn;
        end else begin
            case (ExcMSel)
                2'b01:   sel_code = EXC_ADEL;
                2'b10:   sel_code = EXC_ADES;
                2'b11:   sel_code = EXC_OV;
                default: sel_code = 5'd0;
            endcase
        end
    end

    assign int_req = (|(HWInt & im_q)) & ie_q & ~exl_q;
    assign exc_req = (sel_code != 5'd0) & ~exl_q;
    assign Req     = (int_req | exc_req) & ~reset;

    assign pc_base    = PC & 32'hFFFF_FFFC;
    assign epc_target = BDIn ? (pc_base - 32'd4) : pc_base;

    always_comb begin
        im_d      = im_q;
        exl_d     = exl_q;
        ie_d      = ie_q;
        bd_d      = bd_q;
        ip_d      = HWInt;
        exccode_d = exccode_q;
        epc_d     = epc_q;
        if (Req) begin
            exl_d     = 1'b1;
            bd_d      = BDIn;
            exccode_d = int_req ? 5'd0 : sel_code;
            epc_d     = epc_target;
        end else begin
            if (WE) begin
                if (A2 == REG_SR) begin
                    im_d  = DIn[15:10];
                    exl_d = DIn[1];
                    ie_d  = DIn[0];
                end else if (A2 == REG_EPC) begin
                    epc_d = DIn;
                end
            end
            // eret overrides an SR write landing in the same cycle.
            if (EXLClr) begin
                exl_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            im_q      <= 6'd0;
            exl_q     <= 1'b0;
            ie_q      <= 1'b0;
            bd_q      <= 1'b0;
            ip_q      <= 6'd0;
            exccode_q <= 5'd0;
            epc_q     <= 32'd0;
        end else begin
            im_q      <= im_d;
            exl_q     <= exl_d;
            ie_q      <= ie_d;
            bd_q      <= bd_d;
            ip_q      <= ip_d;
            exccode_q <= exccode_d;
            epc_q     <= epc_d;
        end
    end

    assign sr_val    = {16'd0, im_q, 8'd0, exl_q, ie_q};
    assign cause_val = {bd_q, 15'd0, ip_q, 3'd0, exccode_q, 2'd0};
    assign EPCOut    = epc_q;

    always_comb begin
        case (A1)
            REG_SR:    DOut = sr_val;
            REG_CAUSE: DOut = cause_val;
            REG_EPC:   DOut = epc_q;
            REG_PRID:  DOut = PRID;
            default:   DOut = 32'd0;
        endcase
    end

endmodule
